// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester ports and the memory side of dmem_arbiter.
//   a_*/b_*  : req, we, addr, wdata towards the arbiter; gnt, rdata, rvalid back to the requester
//   mem_*    : read/write strobes, addr, wdata towards memory; combinational mem_rdata back
//   slave modport is the arbiter's view, master modport is the requesters' and memory's view.
interface dmem_arbiter_if;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
        output a_gnt, a_rdata, a_rvalid, b_gnt, b_rdata, b_rvalid,
               mem_read, mem_write, mem_addr, mem_wdata
    );
    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
        input  a_gnt, a_rdata, a_rvalid, b_gnt, b_rdata, b_rvalid,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU A, DMA B) arbiter in front of a single-ported data memory.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave, requester ports A/B and the memory strobes/data
// Optional feature: define DMEM_ARB_FIXED_PRIO_EN to make A win every tie and never be preempted;
// left undefined, ties go round-robin and either owner yields after MAX_HOLD grants.
module dmem_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_b_q, last_b_d;
    logic [31:0] a_rdata_q, b_rdata_q;
    logic        a_rvalid_q, b_rvalid_q;
    logic        a_gnt, b_gnt, hold_up, a_first, a_yields;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign a_first  = 1'b1;
    assign a_yields = 1'b0;
`else
    assign a_first  = last_b_q;
    assign a_yields = 1'b1;
`endif

    assign a_gnt   = (state_q == OWN_A) && bus.a_req;
    assign b_gnt   = (state_q == OWN_B) && bus.b_req;
    // >= rather than == so a waiter still wins after the counter saturated while it was absent
    assign hold_up = cnt_q >= HOLD_LAST;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            OWN_A:   state_d = !bus.a_req ? (bus.b_req ? OWN_B : IDLE)
                             : (bus.b_req && hold_up && a_yields) ? OWN_B : OWN_A;
            OWN_B:   state_d = !bus.b_req ? (bus.a_req ? OWN_A : IDLE)
                             : (bus.a_req && hold_up) ? OWN_A : OWN_B;
            default: state_d = (bus.a_req && (!bus.b_req || a_first)) ? OWN_A
                             : bus.b_req ? OWN_B : IDLE;
        endcase
        cnt_d    = (state_d != state_q) ? 4'd0
                 : ((a_gnt || b_gnt) && cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
        last_b_d = a_gnt ? 1'b0 : b_gnt ? 1'b1 : last_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_b_q   <= 1'b1;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_b_q   <= last_b_d;
            a_rvalid_q <= a_gnt && !bus.a_we;
            b_rvalid_q <= b_gnt && !bus.b_we;
            if (a_gnt && !bus.a_we) a_rdata_q <= bus.mem_rdata;
            if (b_gnt && !bus.b_we) b_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.a_gnt     = a_gnt;
    assign bus.b_gnt     = b_gnt;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.mem_read  = (a_gnt && !bus.a_we) || (b_gnt && !bus.b_we);
    assign bus.mem_write = (a_gnt && bus.a_we) || (b_gnt && bus.b_we);
    assign bus.mem_addr  = a_gnt ? bus.a_addr : b_gnt ? bus.b_addr : '0;
    assign bus.mem_wdata = a_gnt ? bus.a_wdata : b_gnt ? bus.b_wdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with MAX_HOLD=4.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    dmem_arbiter_if bus();

    dmem_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset;
        rst_n = 0;
        clear_inputs();
        next_cycle();
        next_cycle();
        next_cycle();
        rst_n = 1;
    endtask

    task automatic test_reset;
        clear_inputs();
        next_cycle();
        #1;
        total++; if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin bad++; $display("FAIL init_gnt got=%b%b exp=00", bus.a_gnt, bus.b_gnt); end
        total++; if (bus.a_rdata !== 32'h0 || bus.b_rdata !== 32'h0) begin bad++; $display("FAIL init_rdata got=%h/%h exp=0/0", bus.a_rdata, bus.b_rdata); end
        // run a read on A so rvalid/rdata are live, then yank reset
        rst_n = 1;
        bus.a_req = 1; bus.b_req = 1; bus.mem_rdata = 32'hCAFE0001;
        next_cycle();
        next_cycle();
        #1;
        total++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hCAFE0001) begin bad++; $display("FAIL pre_rst_rd got=%b/%h exp=1/cafe0001", bus.a_rvalid, bus.a_rdata); end
        rst_n = 0;
        #1;
        total++; if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b%b exp=00", bus.a_gnt, bus.b_gnt); end
        total++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b%b exp=00", bus.mem_read, bus.mem_write); end
        total++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%b/%h exp=0/0", bus.a_rvalid, bus.a_rdata); end
        total++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem got=%h/%h exp=0/0", bus.mem_addr, bus.mem_wdata); end
        next_cycle();
        rst_n = 1;
        #1;
        total++; if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin bad++; $display("FAIL post_rst_idle got=%b%b exp=00", bus.a_gnt, bus.b_gnt); end
    endtask

    task automatic test_read_latency;
        do_reset();
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h10; bus.mem_rdata = 32'hDEADBEEF;
        #1;
        total++; if (bus.a_gnt !== 1'b0) begin bad++; $display("FAIL rd_c1_gnt got=%b exp=0", bus.a_gnt); end
        next_cycle();
        #1;
        total++; if (bus.a_gnt !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin bad++; $display("FAIL rd_c2_gnt got=%b%b%b exp=110", bus.a_gnt, bus.mem_read, bus.mem_write); end
        total++; if (bus.mem_addr !== 32'h10) begin bad++; $display("FAIL rd_c2_addr got=%h exp=00000010", bus.mem_addr); end
        total++; if (bus.a_rvalid !== 1'b0) begin bad++; $display("FAIL rd_c2_rvalid got=%b exp=0", bus.a_rvalid); end
        next_cycle();
        bus.a_req = 0; bus.mem_rdata = 32'h11111111;
        #1;
        total++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_c3 got=%b/%h exp=1/deadbeef", bus.a_rvalid, bus.a_rdata); end
        total++; if (bus.a_gnt !== 1'b0 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rd_c3_idle got=%b/%h exp=0/0", bus.a_gnt, bus.mem_addr); end
        next_cycle();
        #1;
        total++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_c4_hold got=%b/%h exp=0/deadbeef", bus.a_rvalid, bus.a_rdata); end
    endtask

    task automatic test_simultaneous;
        logic exp_second_a;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_second_a = 1'b1;
`else
        exp_second_a = 1'b0;
`endif
        do_reset();
        bus.a_req = 1; bus.b_req = 1;
        next_cycle();
        #1;
        total++; if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin bad++; $display("FAIL simul_first got=%b%b exp=10", bus.a_gnt, bus.b_gnt); end
        next_cycle();
        bus.a_req = 0; bus.b_req = 0;
        next_cycle();
        bus.a_req = 1; bus.b_req = 1;
        #1;
        total++; if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin bad++; $display("FAIL simul_idle got=%b%b exp=00", bus.a_gnt, bus.b_gnt); end
        next_cycle();
        #1;
        total++; if (bus.a_gnt !== exp_second_a || bus.b_gnt !== !exp_second_a) begin bad++; $display("FAIL simul_second got=%b%b exp=%b%b", bus.a_gnt, bus.b_gnt, exp_second_a, !exp_second_a); end
    endtask

    task automatic test_alternate;
        logic [11:0] pat;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        pat = 12'b1111_1111_1111;
`else
        pat = 12'b1111_0000_1111;
`endif
        do_reset();
        bus.a_req = 1; bus.b_req = 1;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            #1;
            total++; if (bus.a_gnt !== pat[11-i] || bus.b_gnt !== !pat[11-i] || (bus.mem_read && bus.mem_write)) begin bad++; $display("FAIL alt_%0d got=%b%b exp=%b%b", i, bus.a_gnt, bus.b_gnt, pat[11-i], !pat[11-i]); end
        end
`ifdef DMEM_ARB_FIXED_PRIO_EN
        next_cycle();
        bus.a_req = 0;
        #1;
        total++; if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin bad++; $display("FAIL fix_drop got=%b%b exp=00", bus.a_gnt, bus.b_gnt); end
        next_cycle();
        #1;
        total++; if (bus.b_gnt !== 1'b1) begin bad++; $display("FAIL fix_b_after got=%b exp=1", bus.b_gnt); end
`endif
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_write_b;
        do_reset();
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 32'h40; bus.b_wdata = 32'h12345678;
        #1;
        total++; if (bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL wr_c1 got=%b/%h/%h exp=0/0/0", bus.mem_write, bus.mem_addr, bus.mem_wdata); end
        next_cycle();
        #1;
        total++; if (bus.b_gnt !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin bad++; $display("FAIL wr_c2_strobe got=%b%b%b exp=110", bus.b_gnt, bus.mem_write, bus.mem_read); end
        total++; if (bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'h12345678) begin bad++; $display("FAIL wr_c2_bus got=%h/%h exp=00000040/12345678", bus.mem_addr, bus.mem_wdata); end
        next_cycle();
        bus.b_req = 0;
        #1;
        total++; if (bus.mem_write !== 1'b0 || bus.b_rvalid !== 1'b0 || bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL wr_c3 got=%b/%b/%h exp=0/0/0", bus.mem_write, bus.b_rvalid, bus.mem_wdata); end
        next_cycle();
        #1;
        total++; if (bus.b_rvalid !== 1'b0 || bus.b_rdata !== 32'h0) begin bad++; $display("FAIL wr_c4 got=%b/%h exp=0/0", bus.b_rvalid, bus.b_rdata); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.a_req = 1; bus.a_addr = 32'h20; bus.mem_rdata = 32'hA5A5A5A5;
        next_cycle();
        #1;
        total++; if (bus.a_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b exp=1", bus.a_gnt); end
        rst_n = 0;
        next_cycle();
        #1;
        total++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'h0 || bus.a_gnt !== 1'b0) begin bad++; $display("FAIL mid_abort got=%b/%h/%b exp=0/0/0", bus.a_rvalid, bus.a_rdata, bus.a_gnt); end
        rst_n = 1;
        #1;
        total++; if (bus.a_gnt !== 1'b0) begin bad++; $display("FAIL mid_release got=%b exp=0", bus.a_gnt); end
        next_cycle();
        #1;
        total++; if (bus.a_gnt !== 1'b1 || bus.a_rvalid !== 1'b0) begin bad++; $display("FAIL mid_regrant got=%b/%b exp=1/0", bus.a_gnt, bus.a_rvalid); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_hold_saturate;
        logic exp_b;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        do_reset();
        bus.a_req = 1;
        for (int i = 0; i < 20; i++) next_cycle();
        bus.b_req = 1;
        #1;
        total++; if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin bad++; $display("FAIL sat_a_hold got=%b%b exp=10", bus.a_gnt, bus.b_gnt); end
        next_cycle();
        #1;
        total++; if (bus.b_gnt !== exp_b || bus.a_gnt !== !exp_b) begin bad++; $display("FAIL sat_handover got=%b%b exp=%b%b", bus.a_gnt, bus.b_gnt, !exp_b, exp_b); end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_read_latency();
        test_simultaneous();
        test_alternate();
        test_write_b();
        test_reset_mid();
        test_hold_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, max consecutive granted cycles for one requester while the other waits; legal range 1..15.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a_req, b_req  input  1 each  access request, port A = CPU MEM stage, port B = DMA/dump engine.
REQ-005 a_we, b_we  input  1 each  1 = write, 0 = read; sampled only while granted.
REQ-006 a_addr, b_addr  input  32 each  byte address.
REQ-007 a_wdata, b_wdata  input  32 each  write data.
REQ-008 a_gnt, b_gnt  output  1 each  access performed this cycle.
REQ-009 a_rdata, b_rdata  output  32 each  registered read data.
REQ-010 a_rvalid, b_rvalid  output  1 each  one-cycle pulse, rdata valid.
REQ-011 mem_read, mem_write  output  1 each  data memory strobes.
REQ-012 mem_addr, mem_wdata  output  32 each  data memory address/data.
REQ-013 mem_rdata  input  32  combinational memory read data, valid same cycle as mem_read.

Function
REQ-014 FSM states IDLE, OWN_A, OWN_B; state, last-served pointer and hold counter are registered.
REQ-015 IDLE: no request -> IDLE; one request -> OWN of that port; both -> OWN of port not last served.
REQ-016 Arbitration latency: one cycle from req rising in IDLE to gnt.
REQ-017 OWN_x with x_req=1: x_gnt=1 combinationally, mem_read=~x_we, mem_write=x_we, mem_addr=x_addr, mem_wdata=x_wdata.
REQ-018 OWN_x with x_req=0: no gnt, mem strobes 0; next state OWN_y if y_req else IDLE (same cycle decision, no bubble beyond this one).
REQ-019 Hold counter: 4 bits, increments each granted cycle, clears on ownership change or entry to IDLE.
REQ-020 OWN_x, x_req=1, y_req=1, counter = MAX_HOLD-1: grant x this cycle, next state OWN_y.
REQ-021 OWN_x, y_req=0: x keeps ownership indefinitely, counter saturates at 15.
REQ-022 Granted read: mem_rdata captured into x_rdata at the clock edge; x_rvalid=1 the following cycle only.
REQ-023 x_rdata holds last value until next granted read by x; writes never modify rdata.
REQ-024 Never a_gnt and b_gnt together; never mem_read and mem_write together.
REQ-025 When no gnt: mem_addr and mem_wdata = 0.
REQ-026 last-served pointer updates to x on every cycle x_gnt=1.

Reset
REQ-027 rst_n=0 forces immediately: state IDLE, counter 0, last-served = B, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, all gnt and mem strobes 0.
REQ-028 Reset mid-access aborts it: in-flight rvalid is dropped, no pending grant resumes after release.
REQ-029 First cycle after release behaves as IDLE.

Configuration
REQ-030 Macro DMEM_ARB_FIXED_PRIO_EN defined: port A always wins simultaneous requests, REQ-020 applies only to B yielding to A (A is never preempted).
REQ-031 Macro undefined: round-robin per REQ-015 and symmetric preemption per REQ-020.

Verification
REQ-032 Reset, then a_req=1, a_we=0, a_addr=0x10, mem_rdata=0xDEADBEEF -> a_gnt cycle 2, a_rdata=0xDEADBEEF with a_rvalid=1 cycle 3.
REQ-033 From IDLE both req same cycle after reset -> A granted first; second simultaneous arrival from IDLE -> B granted.
REQ-034 MAX_HOLD=4, A and B both held high -> grants alternate AAAABBBBAAAA, never both gnt.
REQ-035 b_req=1 write b_addr=0x40 b_wdata=0x12345678 -> mem_write=1, mem_addr=0x40, mem_wdata=0x12345678 exactly one cycle per gnt, b_rvalid stays 0.
REQ-036 rst_n pulled low during A read gnt cycle -> a_rvalid stays 0, all outputs 0, IDLE after release.
REQ-037 DMEM_ARB_FIXED_PRIO_EN defined, both held high -> A granted every cycle, B never granted until a_req drops.
